// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS front end: FSM encoding, instruction
// field positions and the latched memory request record.
package mips_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        ir_write;
    logic        pc_write;
    logic [31:0] pc_next;
  } mem_req_t;

  function automatic logic is_word_aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction
endpackage

// File: rtl/mips_ir_field_split.sv
// Pure combinational decode of an instruction word into its R/I/J-format fields.
module mips_ir_field_split
  import mips_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [5:0]  o_opcode,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_shamt,
  output logic [5:0]  o_funct,
  output logic [15:0] o_imm16,
  output logic [25:0] o_target26
);
  assign o_opcode   = i_instr[OPC_MSB:OPC_LSB];
  assign o_rs       = i_instr[25:21];
  assign o_rt       = i_instr[20:16];
  assign o_rd       = i_instr[15:11];
  assign o_shamt    = i_instr[10:6];
  assign o_funct    = i_instr[FUNCT_MSB:FUNCT_LSB];
  assign o_imm16    = i_instr[15:0];
  assign o_target26 = i_instr[25:0];
endmodule

// File: rtl/mips_mem_fetch_if.sv
// PC/IR/MDR holder and single memory port for the multicycle MIPS core; stalls the
// controller while memory is busy and traps misaligned or timed-out accesses.
module mips_mem_fetch_if
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          MAX_WAIT = 15,
  parameter int          WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_mem_access,
  input  logic        i_ior_d,
  input  logic        i_mem_write,
  input  logic        i_ir_write,
  input  logic        i_pc_write,
  input  logic [31:0] i_pc_next,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_write_data,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_rd_en,
  output logic        o_mem_wr_en,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic [5:0]  o_opcode,
  output logic [5:0]  o_funct,
  output logic [31:0] o_mdr,
  output logic        o_stall,
  output logic        o_err_misalign,
  output logic        o_err_timeout
);
  logic [1:0]        r_state;
  mem_req_t          r_req;
  logic [WAIT_W-1:0] r_cnt;
  logic [31:0]       r_pc, r_instr, r_mdr;
  logic              r_err_mis, r_err_to;

  logic [31:0] w_addr;
  logic        w_aligned, w_idle, w_wait, w_err;
  logic        w_idle_req, w_req_act, w_done, w_timeout;
  mem_req_t    w_live, w_cur;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_wait     = (r_state == ST_WAIT);
  assign w_err      = (r_state == ST_ERR);
  assign w_addr     = i_ior_d ? i_alu_out : r_pc;
  assign w_aligned  = is_word_aligned(w_addr);
  assign w_idle_req = w_idle & i_mem_access & w_aligned;
  assign w_req_act  = w_idle_req | w_wait;
  assign w_done     = w_req_act & i_mem_ready;
  assign w_timeout  = w_wait & ~i_mem_ready & (r_cnt == WAIT_W'(MAX_WAIT - 1));

  assign w_live = '{addr: w_addr, wdata: i_write_data, write: i_mem_write,
                    ir_write: i_ir_write, pc_write: i_pc_write, pc_next: i_pc_next};
  // Once waiting, the port and the deferred register writes come only from the latch.
  assign w_cur  = w_wait ? r_req : w_live;

  assign o_mem_addr  = w_req_act ? w_cur.addr : '0;
  assign o_mem_wdata = w_req_act ? w_cur.wdata : '0;
  assign o_mem_rd_en = w_req_act & ~w_cur.write;
  assign o_mem_wr_en = w_req_act & w_cur.write;
  assign o_stall     = (w_idle_req & ~i_mem_ready) | (w_wait & ~i_mem_ready) | w_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_req     <= '0;
      r_cnt     <= '0;
      r_err_mis <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_mem_access) begin
            if (!w_aligned) begin
              r_err_mis <= 1'b1;
              r_state   <= ST_ERR;
            end else if (!i_mem_ready) begin
              r_req   <= w_live;
              r_cnt   <= '0;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_mem_ready) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (w_timeout) begin
            r_err_to <= 1'b1;
            r_state  <= ST_ERR;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + WAIT_W'(1);
          end
        end
        default: r_state <= ST_ERR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_mdr   <= '0;
    end else if (w_done) begin
      if (!w_cur.write) begin
        r_mdr <= i_mem_rdata;
        if (w_cur.ir_write) r_instr <= i_mem_rdata;
      end
      if (w_cur.pc_write) r_pc <= w_cur.pc_next;
    end else if (w_idle & ~i_mem_access & i_pc_write) begin
      r_pc <= i_pc_next;
    end
  end

  logic [4:0]  w_unused_rs, w_unused_rt, w_unused_rd, w_unused_shamt;
  logic [15:0] w_unused_imm16;
  logic [25:0] w_unused_target26;

  mips_ir_field_split u_split (
    .i_instr    (r_instr),
    .o_opcode   (o_opcode),
    .o_rs       (w_unused_rs),
    .o_rt       (w_unused_rt),
    .o_rd       (w_unused_rd),
    .o_shamt    (w_unused_shamt),
    .o_funct    (o_funct),
    .o_imm16    (w_unused_imm16),
    .o_target26 (w_unused_target26)
  );

  assign o_pc           = r_pc;
  assign o_instr        = r_instr;
  assign o_mdr          = r_mdr;
  assign o_err_misalign = r_err_mis;
  assign o_err_timeout  = r_err_to;
endmodule

// File: doc/mips_mem_fetch_if.md
Name: mips_mem_fetch_if

Overview:
- Upstream neighbour of the multicycle control unit: holds PC, instruction register (IR) and memory data register (MDR), and drives Opcode/Funct into the controller.
- Owns the single unified memory port with a ready handshake. Asserts stall to freeze the controller FSM while memory is busy.
- Flags misaligned and timed-out accesses.

Parameters:
- RESET_PC, 32'h0040_0000, PC value after reset.
- MAX_WAIT, 15, maximum wait cycles before timeout error (1..255).
- WAIT_W, 8, wait-counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- mem_access  in  1  controller state needs memory (Fetch, MemRead, MemWrite)
- ior_d  in  1  0: address = PC; 1: address = alu_out
- mem_write  in  1  access is a write (else read)
- ir_write  in  1  load IR on read completion
- pc_write  in  1  update PC
- pc_next  in  32  next PC from PCSrc mux
- alu_out  in  32  data address
- write_data  in  32  store data (register B)
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the current access this cycle
- mem_addr  out  32  memory word address (byte address, bits [1:0]=0)
- mem_wdata  out  32  store data to memory
- mem_rd_en  out  1  read request
- mem_wr_en  out  1  write request
- pc  out  32  current PC
- instr  out  32  IR contents
- opcode  out  6  instr[31:26] to controller
- funct  out  6  instr[5:0] to controller
- mdr  out  32  memory data register
- stall  out  1  controller must hold its state this cycle
- err_misalign  out  1  sticky, misaligned access attempted
- err_timeout  out  1  sticky, MAX_WAIT exceeded

Behaviour:
- Reset (async, any state): pc=RESET_PC; instr, mdr = 0; state=IDLE; wait counter=0; both error flags=0; mem_rd_en=mem_wr_en=0; stall=0.
- FSM states: IDLE, WAIT, ERR.
- IDLE, mem_access=0: no request. pc_write loads pc_next at the clock edge (no gating).
- IDLE, mem_access=1:
  - addr = ior_d ? alu_out : pc.
  - If addr[1:0]!=0: no request issued; set err_misalign; go to ERR.
  - Otherwise drive the request combinationally: mem_addr=addr; mem_rd_en=~mem_write; mem_wr_en=mem_write; mem_wdata=write_data.
  - mem_ready=1 same cycle (zero-wait): the access completes and the FSM stays in IDLE.
  - mem_ready=0: latch addr, wdata and direction plus ir_write/pc_write/pc_next; go to WAIT.
- WAIT:
  - Drive only the latched request; live inputs are ignored.
  - stall=1 every cycle in WAIT until completion.
  - Counter increments each cycle. When the count reaches MAX_WAIT with mem_ready=0: set err_timeout, drop the request, go to ERR. The PC/IR/MDR writes are discarded.
- stall (combinational) = (IDLE & mem_access & ~mem_ready & aligned) | (WAIT & ~mem_ready) | ERR.
- Completion cycle (mem_ready=1 with the request active):
  - Read: mdr<=mem_rdata. If the effective ir_write=1, instr<=mem_rdata.
  - Write: mdr unchanged.
  - If the effective pc_write=1: pc<=effective pc_next. "Effective" means the latched values when completing from WAIT.
  - Next state is IDLE. Counter clears.
- While stalled, pc/instr/mdr do not change, even if pc_write/ir_write are asserted.
- ERR: absorbing. stall=1; no requests issued; exit only by reset.
- mem_ready while no request is active: ignored.
- Reset during WAIT: the request drops immediately (async) and no register updates occur.

Decomposition:
- Shared package mips_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, ERR=2'd2), opcode/funct field bit positions, RESET_PC default. The package is shared with the controller.
- One natural sub-module, mips_ir_field_split: purely combinational slicing of instr into opcode, rs, rt, rd, shamt, funct, imm16, target26. It is reused by the datapath.

Test Plan:
- Reset, then fetch with mem_access=1, ior_d=0, ir_write=1, pc_write=1, pc_next=32'h00400004, mem_ready=1, mem_rdata=32'h2008000A -> mem_addr=32'h00400000 and mem_rd_en=1 in that cycle; after the edge, instr=32'h2008000A, opcode=6'h08, pc=32'h00400004, stall never high.
- Fetch with mem_ready held 0 for 3 cycles then 1; live pc_next changed to 32'hDEAD0000 during the wait -> stall=1 for exactly 3 cycles, mem_addr stable, pc=32'h00400004 (latched value) after completion.
- Store: ior_d=1, alu_out=32'h10010008, mem_write=1, write_data=32'hCAFEF00D, mem_ready=1 -> mem_wr_en=1, mem_wdata=32'hCAFEF00D, mdr unchanged, pc unchanged.
- Load with alu_out=32'h10010006 -> no rd/wr enable ever asserted, err_misalign=1, stall=1 permanently until rst pulse, which clears it and restores pc=32'h00400000.
- Read with mem_ready=0 for 16 cycles (MAX_WAIT=15) -> err_timeout=1 after 15 wait cycles, request drops, instr/mdr/pc unchanged.
- Assert rst mid-WAIT -> mem_rd_en=0 immediately without a clock edge; pc=RESET_PC, state IDLE.
